// File: rtl/blk_cbfb5a_pkg.sv
// Shared definitions for the fracturable 8x8 multiplier.
//   - Operand width constants (fixed configuration).
//   - Mode encoding and the HALF_* priority decode.
package blk_cbfb5a_pkg;

    localparam int unsigned A_chop_size = 8;
    localparam int unsigned B_chop_size = 8;

    // Number of 2-bit chunks per operand.
    localparam int unsigned NumChunks = A_chop_size / 2;

    typedef enum logic [1:0] {
        MODE_8X8 = 2'd0,
        MODE_4X4 = 2'd1,
        MODE_2X2 = 2'd2
    } mode_e;

    // HALF_2 wins over HALF_1, which wins over HALF_0; all-low falls back to 8x8.
    function automatic mode_e decode_mode(input logic half_0, input logic half_1,
                                          input logic half_2);
        mode_e m;
        if (half_2) begin
            m = MODE_2X2;
        end else if (half_1) begin
            m = MODE_4X4;
        end else if (half_0) begin
            m = MODE_8X8;
        end else begin
            m = MODE_8X8;
        end
        return m;
    endfunction

endpackage

// File: rtl/blk_cbfb5a_mult_2x2_chunk.sv
// 2x2 partial-product cell.
//   a, b           : 2-bit operand chunks
//   a_signed       : 1 = a[1] carries negative weight (chunk is a lane MSB of a signed operand)
//   b_signed       : same for b
//   p              : exact product as 6-bit two's complement
module blk_cbfb5a_mult_2x2_chunk (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       a_signed,
    input  logic       b_signed,
    output logic [5:0] p
);

    logic signed [2:0] a_ext;
    logic signed [2:0] b_ext;
    logic signed [5:0] prod;

    assign a_ext = {a_signed & a[1], a};
    assign b_ext = {b_signed & b[1], b};
    assign prod  = a_ext * b_ext;
    assign p     = prod;

endmodule

// File: rtl/blk_cbfb5a.sv
// Precision-configurable 8x8 multiplier with 8x8, 2x(4x4) and 4x(2x2) lane modes.
//   clk, reset     : clock, asynchronous active-high reset (clears C)
//   A, B           : packed lane operands
//   A_sign, B_sign : 1 = lanes of that operand are two's complement
//   HALF_0/1/2     : mode select 8x8 / 4x4 / 2x2 (HALF_2 highest priority)
//   C              : packed lane products, registered (1-cycle latency)
module blk_cbfb5a
    import blk_cbfb5a_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [A_chop_size-1:0] A,
    input  logic [B_chop_size-1:0] B,
    input  logic                   A_sign,
    input  logic                   B_sign,
    input  logic                   HALF_0,
    input  logic                   HALF_1,
    input  logic                   HALF_2,
    output logic [15:0]            C
);

    mode_e                mode;
    logic [NumChunks-1:0] a_sgn;
    logic [NumChunks-1:0] b_sgn;
    logic [5:0]           term [NumChunks*NumChunks];
    logic [15:0]          sum8;
    logic [7:0]           sum4 [2];
    logic [15:0]          prod_4x4;
    logic [15:0]          prod_2x2;
    logic [15:0]          c_d;
    logic [15:0]          c_q;

    assign mode = decode_mode(HALF_0, HALF_1, HALF_2);

    // A chunk's MSB carries negative weight only when it is the top chunk of its lane.
    always_comb begin
        a_sgn = '0;
        b_sgn = '0;
        case (mode)
            MODE_4X4: begin
                a_sgn = {A_sign, 1'b0, A_sign, 1'b0};
                b_sgn = {B_sign, 1'b0, B_sign, 1'b0};
            end
            MODE_2X2: begin
                a_sgn = {NumChunks{A_sign}};
                b_sgn = {NumChunks{B_sign}};
            end
            default: begin
                a_sgn = {A_sign, 3'b000};
                b_sgn = {B_sign, 3'b000};
            end
        endcase
    end

    for (genvar gi = 0; gi < NumChunks; gi++) begin : g_a
        for (genvar gj = 0; gj < NumChunks; gj++) begin : g_b
            blk_cbfb5a_mult_2x2_chunk u_chunk (
                .a        (A[2*gi +: 2]),
                .b        (B[2*gj +: 2]),
                .a_signed (a_sgn[gi]),
                .b_signed (b_sgn[gj]),
                .p        (term[gi*NumChunks+gj])
            );
        end
    end

    // Every term sits at its natural weight 4^(i+j) in all modes; lanes differ only in
    // which terms they sum and where the sum is truncated, which keeps carries in-lane.
    always_comb begin
        sum8 = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                sum8 = sum8 + ({{10{term[i*4+j][5]}}, term[i*4+j]} << (2 * (i + j)));
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            sum4[k] = '0;
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    sum4[k] = sum4[k] + ({{2{term[(2*k+i)*4+2*k+j][5]}},
                                          term[(2*k+i)*4+2*k+j]} << (2 * (i + j)));
                end
            end
        end
        prod_4x4 = {sum4[1], sum4[0]};
    end

    // Diagonal cells are exactly the 2x2 lane products.
    always_comb begin
        prod_2x2 = '0;
        for (int k = 0; k < 4; k++) begin
            prod_2x2[4*k +: 4] = term[5*k][3:0];
        end
    end

    always_comb begin
        c_d = sum8;
        case (mode)
            MODE_4X4: c_d = prod_4x4;
            MODE_2X2: c_d = prod_2x2;
            default:  c_d = sum8;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign C = c_q;

endmodule

// File: tb/tb_blk_cbfb5a.sv
module tb_blk_cbfb5a;

    logic        clk;
    logic        reset;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        A_sign;
    logic        B_sign;
    logic        HALF_0;
    logic        HALF_1;
    logic        HALF_2;
    logic [15:0] C;

    int errors = 0;
    int checks = 0;

    blk_cbfb5a dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .A_sign (A_sign),
        .B_sign (B_sign),
        .HALF_0 (HALF_0),
        .HALF_1 (HALF_1),
        .HALF_2 (HALF_2),
        .C      (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent lane model: extend each lane as an integer, multiply, truncate.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                            input logic as_, input logic bs_, input int n);
        int la, lb, p;
        logic [15:0] res;
        res = '0;
        for (int k = 0; k < 8 / n; k++) begin
            la = (int'(a) >> (n * k)) & ((1 << n) - 1);
            lb = (int'(b) >> (n * k)) & ((1 << n) - 1);
            if (as_ && ((la >> (n - 1)) & 1) == 1) la = la - (1 << n);
            if (bs_ && ((lb >> (n - 1)) & 1) == 1) lb = lb - (1 << n);
            p = (la * lb) & ((1 << (2 * n)) - 1);
            res = res | 16'(p << (2 * n * k));
        end
        return res;
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic as_,
                         input logic bs_, input logic [2:0] h);
        A      = a;
        B      = b;
        A_sign = as_;
        B_sign = bs_;
        {HALF_2, HALF_1, HALF_0} = h;
    endtask

    task automatic run_vec(input logic [7:0] a, input logic [7:0] b, input logic as_,
                           input logic bs_, input logic [2:0] h, input logic [15:0] exp,
                           input string tag);
        @(negedge clk);
        drive(a, b, as_, bs_, h);
        @(posedge clk);
        #1;
        check_eq(tag, C, exp);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        as_;
        logic        bs_;
        logic [2:0]  h;   // {HALF_2, HALF_1, HALF_0}
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 3'b001, 16'hFE01};
        vecs[1]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 3'b001, 16'h0000};
        vecs[2]  = '{8'h80, 8'h80, 1'b1, 1'b1, 3'b001, 16'h4000};
        vecs[3]  = '{8'h80, 8'h7F, 1'b1, 1'b1, 3'b001, 16'hC080};
        vecs[4]  = '{8'hF3, 8'hF2, 1'b0, 1'b0, 3'b010, 16'hE106};
        vecs[5]  = '{8'h87, 8'h83, 1'b1, 1'b1, 3'b010, 16'h4015};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 3'b100, 16'h9999};
        vecs[7]  = '{8'hAA, 8'hAA, 1'b1, 1'b1, 3'b100, 16'h4444};
        vecs[8]  = '{8'hAA, 8'h55, 1'b1, 1'b1, 3'b100, 16'hEEEE};
        vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 3'b001, 16'hFF01};
        vecs[10] = '{8'hAA, 8'hAA, 1'b1, 1'b1, 3'b110, 16'h4444};
        vecs[11] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 3'b000, 16'hFE01};
        vecs[12] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 3'b111, 16'h9999};
        vecs[13] = '{8'hF3, 8'hF2, 1'b0, 1'b0, 3'b011, 16'hE106};
        vecs[14] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 3'b100, 16'hDDDD};  // -1*3 per lane
        vecs[15] = '{8'h7F, 8'h80, 1'b1, 1'b1, 3'b010, 16'hC800};  // 7*-8, -1*0

        reset = 1'b1;
        drive(8'h00, 8'h00, 1'b0, 1'b0, 3'b001);
        #1;
        check_eq("reset_c", C, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_hold", C, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_vec(vecs[i].a, vecs[i].b, vecs[i].as_, vecs[i].bs_, vecs[i].h, vecs[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Output holds between edges even when inputs change.
        run_vec(8'hFF, 8'hFF, 1'b0, 1'b0, 3'b001, 16'hFE01, "pre_hold");
        @(negedge clk);
        drive(8'h12, 8'h34, 1'b0, 1'b0, 3'b100);
        #1;
        check_eq("hold_between_edges", C, 16'hFE01);
        @(posedge clk);
        #1;
        check_eq("after_hold", C, ref_mul(8'h12, 8'h34, 1'b0, 1'b0, 2));

        // Asynchronous reset mid-cycle while C is nonzero.
        run_vec(8'hFF, 8'hFF, 1'b0, 1'b0, 3'b001, 16'hFE01, "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_reset", C, 16'h0000);
        @(posedge clk);
        #1;
        check_eq("reset_over_edge", C, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        drive(8'hF3, 8'hF2, 1'b0, 1'b0, 3'b010);
        @(posedge clk);
        #1;
        check_eq("post_reset", C, 16'hE106);

        // Random sweep over every mode and signedness combination.
        for (int m = 0; m < 3; m++) begin
            for (int s = 0; s < 4; s++) begin
                for (int it = 0; it < 100; it++) begin
                    logic [7:0] ra, rb;
                    logic [2:0] h;
                    int n;
                    ra = 8'($urandom_range(255));
                    rb = 8'($urandom_range(255));
                    h  = (m == 0) ? 3'b001 : (m == 1) ? 3'b010 : 3'b100;
                    n  = (m == 0) ? 8 : (m == 1) ? 4 : 2;
                    run_vec(ra, rb, s[1], s[0], h, ref_mul(ra, rb, s[1], s[0], n),
                            $sformatf("rand_m%0d_s%0d_a%h_b%h", m, s, ra, rb));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
